// File: rtl/line_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : line_memory_responder
// Brief    : Fixed-latency line-granular memory responder for the D-cache port.
//            Optional MEM_RANGE_CHECK_EN flags addresses beyond DEPTH_LINES.
// Revision : 1.0
// ============================================================================
module line_memory_responder #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_SIZE  = 256,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BLOCK_SIZE-1:0] mem_wr,
    input  logic                  mem_rw,
    input  logic                  mem_valid,
    output logic [BLOCK_SIZE-1:0] mem_rd,
    output logic                  mem_ready,
    output logic                  mem_err
);

    localparam int c_IDX_W   = $clog2(DEPTH_LINES);
    localparam int c_IDX_LSB = 3;
    localparam int c_CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [c_CNT_W-1:0]    cnt_q, cnt_d;
    logic [c_IDX_W-1:0]    idx_q, idx_d;
    logic                  rw_q, rw_d;
    logic                  oor_q, oor_d;
    logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [BLOCK_SIZE-1:0] rd_q, rd_d;

    logic                  w_addr_oor;
    logic                  w_resp_entry;
    logic                  w_mem_we;
    logic                  w_unused_addr;

    logic [BLOCK_SIZE-1:0] mem_array [DEPTH_LINES];

    assign w_unused_addr = ^mem_addr;

    generate
`ifdef MEM_RANGE_CHECK_EN
        if (ADDR_WIDTH > c_IDX_LSB + c_IDX_W) begin : g_range_chk
            assign w_addr_oor = |mem_addr[ADDR_WIDTH-1:c_IDX_LSB+c_IDX_W];
        end else begin : g_range_no_upper
            assign w_addr_oor = 1'b0;
        end
`else
        if (1) begin : g_range_off
            assign w_addr_oor = 1'b0;
        end
`endif
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_d    = rw_q;
        oor_d   = oor_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    idx_d   = mem_addr[c_IDX_LSB +: c_IDX_W];
                    rw_d    = mem_rw;
                    oor_d   = w_addr_oor;
                    wdata_d = mem_wr;
                    cnt_d   = c_CNT_LOAD;
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mem_valid) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                    if (cnt_q == c_CNT_ONE) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The _d request fields are the live request here: inputs when
        // accepting straight from IDLE, latched copies otherwise.
        w_resp_entry = (state_d == S_RESP);
        w_mem_we     = w_resp_entry && rw_d && !oor_d && !rst;
        ready_d      = w_resp_entry;
        err_d        = w_resp_entry && oor_d;
        rd_d         = (w_resp_entry && !rw_d && !oor_d) ? mem_array[idx_d] : '0;
    end

    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            oor_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rw_q    <= rw_d;
            oor_q   <= oor_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    // Backing store is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_array[idx_d] <= wdata_d;
        end
    end

    assign mem_rd    = rd_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;

endmodule
`default_nettype wire

// File: doc/line_memory_responder.md
# line_memory_responder

Main-memory responder for the D-cache line interface: accepts one 256-bit line read or write per request from the cache controller's memory port and answers with a single-cycle `mem_ready` pulse after a fixed, configurable latency. It sits between the cache controller and the on-chip backing store (synthesis target) and doubles as the memory model in cache benches.

## Interface
- `ADDR_WIDTH`, 28, width of `mem_addr` (32-bit word address; bits [2:0] are word-in-line offset)
- `BLOCK_SIZE`, 256, line width in bits
- `DEPTH_LINES`, 1024, number of lines stored; power of two, ≥2
- `LATENCY`, 4, cycles from request acceptance to `mem_ready`; integer ≥1
- `clk` in 1 — single clock, all logic rising-edge
- `rst` in 1 — reset, synchronous, active-high
- `mem_addr` in ADDR_WIDTH — request word address; bits [2:0] ignored
- `mem_wr` in BLOCK_SIZE — write line data
- `mem_rw` in 1 — 1 = write, 0 = read
- `mem_valid` in 1 — request present; requester holds addr/rw/wr stable until `mem_ready`
- `mem_rd` out BLOCK_SIZE — read line data; valid only while `mem_ready` = 1, else 0
- `mem_ready` out 1 — one-cycle completion pulse
- `mem_err` out 1 — out-of-range flag, coincident with `mem_ready` (see Configuration)

## Operation
- Line index = `mem_addr[3 +: log2(DEPTH_LINES)]`; array of DEPTH_LINES × BLOCK_SIZE, not cleared by reset.
- States: IDLE, WAIT, RESP.
- IDLE: if `mem_valid`=1, latch index, rw, write data; load down-counter with LATENCY-1; go WAIT (or RESP directly when LATENCY=1). Else stay.
- WAIT: if `mem_valid`=0 → abort, IDLE, no array write, no `mem_ready`. Else decrement; on counter = 0 → RESP.
- Edge entering RESP: write → array[index] ← latched data; read → `mem_rd` register ← array[index]. `mem_ready` register set.
- RESP: `mem_ready`=1 for exactly this cycle; next state IDLE unconditionally (even if `mem_valid` drops during RESP; the write is already committed).
- IDLE following RESP re-samples `mem_valid`: a still-high `mem_valid` is a new request (cache moves WRITE_BACK→ALLOCATE without dropping valid).
- Write responses: `mem_rd` = 0 during `mem_ready`.
- Address/data changes while WAIT are ignored (latched values used).

## Timing
- Request seen in IDLE in cycle t → `mem_ready`=1 in cycle t+LATENCY, 0 in t+LATENCY+1.
- Back-to-back: next request accepted at t+LATENCY+1 at earliest; throughput one line per LATENCY+1 cycles.
- Read-after-write to same line: read returns new data (write committed at entry to RESP).
- Reset: state IDLE, counter 0, `mem_ready`=0, `mem_rd`=0, `mem_err`=0 in the cycle after `rst` sampled high; in-flight request dropped, its write not performed unless RESP already entered. Reset takes priority over all transitions.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `MEM_RANGE_CHECK_EN` defined: at acceptance, if any `mem_addr` bit above the line index field is 1, request is flagged out-of-range; it completes with normal latency, `mem_ready`=1 and `mem_err`=1 in RESP, write suppressed, `mem_rd`=0.
- Not defined: upper bits ignored (addresses alias modulo DEPTH_LINES lines); `mem_err` tied 0.

## Test plan
- Write then read, LATENCY=4: write line `mem_addr`=28'h0000_040 data = 256'h…A5A5 (pattern) → `mem_ready` 4 cycles after accept, `mem_rd`=0; read same addr → `mem_ready` 4 cycles later with `mem_rd`=pattern, exactly one-cycle pulse.
- Back-to-back without dropping valid: write addr 0x100 then immediately read addr 0x200 (preloaded 256'h1) → second accept at t+5, `mem_ready` at t+4 and t+9, read data 256'h1.
- Abort: read request, drop `mem_valid` after 2 cycles of WAIT → no `mem_ready`; write request aborted likewise → subsequent read of that line returns old contents.
- LATENCY=1: read request at t → `mem_ready` at t+1; offset bits 0x7 vs 0x0 return identical line.
- Reset mid-WAIT of a write to 0x300 → outputs 0 next cycle, state IDLE, line 0x300 unchanged; first post-reset request completes with normal latency.
- Range check: with `MEM_RANGE_CHECK_EN`, DEPTH_LINES=1024, write to 28'h800_0000 → `mem_ready`=`mem_err`=1, line 0 unchanged; without macro, same write lands in line 0, `mem_err`=0.
